// File: rtl/c499_chk_pkg.sv
// Shared types and constants for the c499 response checker.
package c499_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          C499_OUT_WIDTH = 32;
  // x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] MISR_POLY      = 32'h0040_0007;

endpackage

// File: rtl/c499_misr.sv
// Multiple-input signature register: shift left, fold the MSB back through
// the feedback polynomial, and xor in the parallel response word.
module c499_misr
  import c499_chk_pkg::*;
#(
  parameter int           W    = C499_OUT_WIDTH,
  parameter logic [W-1:0] SEED = '0,
  parameter logic [W-1:0] POLY = W'(MISR_POLY)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sig_q <= SEED;
    else     sig_q <= sig_d;
  end

  assign q = sig_q;

endmodule

// File: rtl/c499_response_checker.sv
// Compares streamed c499 responses with a golden memory (1-cycle read latency).
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting responses, one compare in flight behind each acceptance
// DRAIN | last compare completes
// DONE  | results held until start
module c499_response_checker
  import c499_chk_pkg::*;
#(
  parameter int                   OUT_WIDTH  = C499_OUT_WIDTH,
  parameter int                   VEC_LENGTH = 8,
  parameter logic [OUT_WIDTH-1:0] MISR_SEED  = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              resp_valid,
  input  logic [OUT_WIDTH-1:0]              resp_data,
  output logic [$clog2(VEC_LENGTH)-1:0]     exp_addr,
  input  logic [OUT_WIDTH-1:0]              exp_data,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [$clog2(VEC_LENGTH+1)-1:0]   mismatch_count,
  output logic [$clog2(VEC_LENGTH)-1:0]     first_fail_idx,
  output logic [OUT_WIDTH-1:0]              signature
);

  localparam int            IW       = $clog2(VEC_LENGTH);
  localparam int            CW       = $clog2(VEC_LENGTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(VEC_LENGTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(VEC_LENGTH);

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [OUT_WIDTH-1:0]   s1_resp_q, s1_resp_d;
  logic [IW-1:0]          s1_idx_q, s1_idx_d;
  logic                   s1_vld_q, s1_vld_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          ffi_q, ffi_d;
  logic                   seen_q, seen_d;
  logic                   pass_q, pass_d;
  logic                   accept, enter_run, mismatch;

  always_comb begin
    accept    = (state_q == RUN) && resp_valid;
    enter_run = start && ((state_q == IDLE) || (state_q == DONE));
    mismatch  = s1_vld_q && (s1_resp_q != exp_data);

    state_d = state_q;
    case (state_q)
      IDLE:    if (enter_run) state_d = RUN;
      RUN:     if (accept && (idx_q == LAST_IDX)) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (enter_run) state_d = RUN;
      default: state_d = IDLE;
    endcase

    idx_d     = idx_q;
    s1_resp_d = s1_resp_q;
    s1_idx_d  = s1_idx_q;
    s1_vld_d  = accept;
    if (enter_run) begin
      idx_d = '0;
    end else if (accept) begin
      idx_d     = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      s1_resp_d = resp_data;
      s1_idx_d  = idx_q;
    end

    cnt_d  = cnt_q;
    ffi_d  = ffi_q;
    seen_d = seen_q;
    if (enter_run) begin
      cnt_d  = '0;
      ffi_d  = '0;
      seen_d = 1'b0;
    end else if (mismatch) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (!seen_q) begin
        ffi_d  = s1_idx_q;
        seen_d = 1'b1;
      end
    end

    // DRAIN's compare is the last one, so the verdict is final on entry to DONE.
    pass_d = 1'b0;
    if (state_q == DRAIN)                   pass_d = (cnt_d == '0);
    else if (state_q == DONE && !enter_run) pass_d = pass_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      s1_resp_q <= '0;
      s1_idx_q  <= '0;
      s1_vld_q  <= 1'b0;
      cnt_q     <= '0;
      ffi_q     <= '0;
      seen_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      s1_resp_q <= s1_resp_d;
      s1_idx_q  <= s1_idx_d;
      s1_vld_q  <= s1_vld_d;
      cnt_q     <= cnt_d;
      ffi_q     <= ffi_d;
      seen_q    <= seen_d;
      pass_q    <= pass_d;
    end
  end

  c499_misr #(
    .W    (OUT_WIDTH),
    .SEED (MISR_SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (enter_run),
    .en   (accept),
    .d    (resp_data),
    .q    (signature)
  );

  assign exp_addr       = idx_q;
  assign busy           = (state_q == RUN) || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign mismatch_count = cnt_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: doc/c499_response_checker.md
# c499_response_checker

On-chip response checker for the c499 aging experiment, the consuming end of the vector stream. The stimulus side drives 41-bit input vectors into c499 and captures its 32 outputs (N724–N755). This block takes those 32-bit output responses and compares each against a golden vector read from a synchronous expected-response memory. It counts mismatches, records the first failing index, and compacts all responses into a 32-bit MISR signature, so long aging runs need no file dump.

## Interface
- `OUT_WIDTH`, 32, response width (c499 outputs, N724 = MSB)
- `VEC_LENGTH`, 8, responses per run
- `MISR_SEED`, 32'h0000_0000, signature value loaded at run start
- `clk`  in  1  sole clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begins a run; sampled only in IDLE or DONE
- `resp_valid`  in  1  resp_data holds a c499 response this cycle
- `resp_data`  in  OUT_WIDTH  c499 outputs {N724..N755}
- `exp_addr`  out  $clog2(VEC_LENGTH)  index into expected memory
- `exp_data`  in  OUT_WIDTH  expected memory read data, valid 1 cycle after exp_addr
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  high in DONE, held until start or rst
- `pass`  out  1  valid while done; 1 iff mismatch_count == 0
- `mismatch_count`  out  $clog2(VEC_LENGTH+1)  mismatching responses, saturating
- `first_fail_idx`  out  $clog2(VEC_LENGTH)  index of first mismatch; 0 if none
- `signature`  out  OUT_WIDTH  MISR state

## Operation
- FSM states:
  - IDLE: start moves to RUN.
  - RUN: on the VEC_LENGTH-th acceptance, moves to DRAIN.
  - DRAIN: always moves to DONE after one cycle.
  - DONE: start moves to RUN.
- Entering RUN does all of the following:
  - idx = 0
  - mismatch_count = 0
  - first_fail_idx = 0
  - first-fail flag cleared
  - signature = MISR_SEED
- Acceptance happens only when state == RUN and resp_valid == 1.
- On each acceptance:
  - resp_data is registered into stage-1 as resp_q, together with idx_q = idx.
  - idx increments.
  - signature updates.
- exp_addr = idx (registered), so exp_data in the following cycle belongs to idx_q.
- Stage-2 compare runs in the cycle after an acceptance. A mismatch is resp_q != exp_data (any bit).
- On a mismatch:
  - mismatch_count increments, saturating at VEC_LENGTH.
  - If the first-fail flag is clear, first_fail_idx = idx_q and the flag is set.
- MISR: sig_next = {sig[30:0],1'b0} ^ (sig[31] ? 32'h0040_0007 : 0) ^ resp_data. The polynomial is x^32+x^22+x^2+x+1.
- Ignored inputs:
  - resp_valid outside RUN is ignored, including in DRAIN.
  - start in RUN or DRAIN is ignored.
- Gaps in resp_valid are legal. Compare happens only for accepted responses.

## Timing
- Reset values: state IDLE, busy 0, done 0, pass 0, mismatch_count 0, first_fail_idx 0, signature MISR_SEED, exp_addr 0.
- Start sampled at edge S gives RUN from S. The earliest acceptance is edge S+1.
- Compare latency is 1 cycle. A counter update from acceptance edge A is visible after edge A+1.
- The last acceptance at edge E moves the FSM to DRAIN. The final compare registers at E+1, and done/pass are valid from E+1.
- With back-to-back resp_valid and start at edge 0, accepts occur at edges 1..8 and done rises after edge 9.
- pass = done && (mismatch_count == 0). It is registered and never glitches mid-run.
- rst mid-run aborts immediately and all outputs return to reset values. A pending stage-2 compare is discarded.
- start in DONE with resp_valid high: that cycle's response is not accepted. Acceptance begins the next edge.

## Structure
- Package `c499_chk_pkg` holds:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - `MISR_POLY = 32'h0040_0007`
  - `C499_OUT_WIDTH = 32`
- Sub-module `c499_misr` holds the 32-bit MISR register, with ports clk, rst, load (seed), en, d, q.
- The top level holds the FSM, index counter, stage-1 register, comparator and result registers.

## Test plan
- **All match:** 8 responses equal to memory, resp_valid continuous → done after edge 9, pass=1, mismatch_count=0, first_fail_idx=0.
- **Single error:** response 3 has bit 5 flipped → mismatch_count=1, first_fail_idx=3, pass=0. Responses 3 and 6 corrupted → count=2, first_fail_idx=3.
- **Bursty valid:** same 8 responses with random 0–3 cycle gaps → results identical to the all-match case. done rises exactly 2 edges after the 8th accepted valid, counting the acceptance edge.
- **MISR:** VEC_LENGTH=2, seed 0, responses 32'h8000_0000 then 32'h0000_0000 → signature 32'h8000_0000 after the first, 32'h0040_0007 final.
- **Reset mid-run:** rst after 4 accepts → all outputs reach reset values the next cycle. A new start plus 8 matching responses gives pass=1.
- **Ignored inputs:** resp_valid pulses in IDLE and DONE, and start asserted in RUN → no acceptance, no restart, counters unchanged.
